// File: rtl/stim_seq_pkg.sv
// Shared types and constants for the stimulus sequencer: program word
// layout, command and state encodings, and the timer operation codes.
package stim_seq_pkg;

  localparam int WORD_W      = 16;
  localparam int STIM_W      = 12;
  localparam int PAYLOAD_MSB = 11;
  localparam int HOLD_LSB    = 12;
  localparam int CMD_LSB     = 14;
  localparam int HOLD_W      = 2;
  localparam int CMD_W       = 2;
  localparam int TMR_W       = 8;

  typedef enum logic [CMD_W-1:0] {
    CMD_APPLY    = 2'b00,
    CMD_WAIT_CTS = 2'b01,
    CMD_WAIT_CTR = 2'b10,
    CMD_END      = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    APPLY,
    WAIT,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    TMR_KEEP,
    TMR_LOAD,
    TMR_DEC,
    TMR_INC
  } tmr_op_e;

  typedef struct packed {
    cmd_e              cmd;
    logic [HOLD_W-1:0] hold;
    logic [STIM_W-1:0] payload;
  } word_t;

  // Split a raw program word into its fields.
  function automatic word_t decode_word(input logic [WORD_W-1:0] w);
    word_t f;
    f.payload = w[PAYLOAD_MSB:0];
    f.hold    = w[HOLD_LSB +: HOLD_W];
    f.cmd     = cmd_e'(w[CMD_LSB +: CMD_W]);
    return f;
  endfunction

endpackage

// File: rtl/stim_seq_timer.sv
// Single 8-bit counter shared by the APPLY hold countdown and the WAIT
// timeout count-up. The two uses never overlap, so one register suffices.
module stim_seq_timer
  import stim_seq_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  tmr_op_e           op,
  input  logic [HOLD_W-1:0] load_val,
  output logic              zero,
  output logic              term
);

  logic [TMR_W-1:0] cnt_q;
  logic [TMR_W-1:0] cnt_d;

  // Next count from the requested operation.
  always_comb begin
    // NOTE: default first so every path assigns cnt_d; no latch is inferred.
    cnt_d = cnt_q;
    case (op)
      TMR_LOAD: cnt_d = TMR_W'(load_val);
      TMR_DEC:  cnt_d = cnt_q - TMR_W'(1);
      TMR_INC:  cnt_d = cnt_q + TMR_W'(1);
      default:  cnt_d = cnt_q;
    endcase
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking so all flops update together from pre-edge values.
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);
  // Terminal when this cycle is the TIMEOUT-th wait cycle (count started at 0).
  assign term = (cnt_q == TMR_W'(TIMEOUT - 1));

endmodule

// File: rtl/stim_sequencer.sv
// Programmable stimulus engine: fetches 16-bit words, drives the 12-bit
// payload to the target DUT for hold+1 cycles, optionally stalls on the
// cts/ctr handshake, and stops on END, LAST_ADDR, timeout or halt.
module stim_sequencer
  import stim_seq_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int LAST_ADDR = 1000,
  parameter int TIMEOUT   = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic              halt,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              cts,
  input  logic              ctr,
  output logic [STIM_W-1:0] stim_out,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(LAST_ADDR);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [STIM_W-1:0] stim_q, stim_d;
  cmd_e              cmd_q, cmd_d;
  logic              terr_q, terr_d;

  tmr_op_e           tmr_op;
  logic [HOLD_W-1:0] tmr_load_val;
  logic              tmr_zero;
  logic              tmr_term;

  word_t             word;
  logic              advance;
  logic              wait_sig;

  assign word     = decode_word(mem_rdata);
  assign wait_sig = (cmd_q == CMD_WAIT_CTS) ? cts : ctr;

  stim_seq_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .op       (tmr_op),
    .load_val (tmr_load_val),
    .zero     (tmr_zero),
    .term     (tmr_term)
  );

  // Next-state, program counter, stimulus and timer control.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    stim_d       = stim_q;
    cmd_d        = cmd_q;
    terr_d       = terr_q;
    tmr_op       = TMR_KEEP;
    tmr_load_val = '0;
    advance      = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (run && !halt) begin
          state_d = FETCH;
          pc_d    = '0;
          terr_d  = 1'b0;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        if (word.cmd == CMD_END) begin
          state_d = DONE;
        end else begin
          stim_d       = word.payload;
          cmd_d        = word.cmd;
          tmr_op       = TMR_LOAD;
          tmr_load_val = word.hold;
          state_d      = APPLY;
        end
      end
      APPLY: begin
        if (!tmr_zero) begin
          tmr_op = TMR_DEC;
        end else if (cmd_q == CMD_APPLY) begin
          advance = 1'b1;
        end else begin
          tmr_op  = TMR_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (wait_sig) begin
          advance = 1'b1;
        end else if (tmr_term) begin
          terr_d  = 1'b1;
          state_d = DONE;
        end else begin
          tmr_op = TMR_INC;
        end
      end
      default: state_d = IDLE;
    endcase

    // Finishing a word: stop at the last address, otherwise fetch the next.
    if (advance) begin
      if (pc_q == LAST_PC) begin
        state_d = DONE;
      end else begin
        pc_d    = pc_q + ADDR_W'(1);
        state_d = FETCH;
      end
    end

    // Abort overrides everything except the sticky timeout flag.
    if (halt && state_q != IDLE) begin
      state_d = IDLE;
      pc_d    = '0;
      stim_d  = '0;
      terr_d  = terr_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      stim_q  <= '0;
      cmd_q   <= CMD_APPLY;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      stim_q  <= stim_d;
      cmd_q   <= cmd_d;
      terr_q  <= terr_d;
    end
  end

  assign mem_rd      = (state_q == FETCH);
  assign mem_addr    = pc_q;
  assign pc          = pc_q;
  assign stim_out    = stim_q;
  assign busy        = (state_q == FETCH) || (state_q == LOAD) ||
                       (state_q == APPLY) || (state_q == WAIT);
  assign done        = (state_q == DONE);
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_stim_sequencer.sv
// Directed bench for stim_sequencer: program timing, handshake wait,
// timeout, halt/run interaction, reset mid-run and the LAST_ADDR stop.
module tb_stim_sequencer;

  logic        clock = 1'b0;
  logic        reset, run, run3, halt, cts, ctr;
  logic        mem_rd, mem_rd3;
  logic [9:0]  mem_addr, mem_addr3, pc, pc3;
  logic [15:0] rdata, rdata3;
  logic [11:0] stim, stim3;
  logic        busy, done, terr, busy3, done3, terr3;

  logic [15:0] mem [0:1023];
  logic [11:0] st [0:15];
  logic        dn [0:15];
  logic        rd [0:15];
  int          max_addr3 = 0;
  int          n_checks  = 0;
  int          n_errors  = 0;

  always #5 clock = ~clock;

  // Program memory model: word valid the cycle after the read strobe.
  always @(posedge clock) begin
    if (mem_rd)  rdata  <= mem[mem_addr];
    if (mem_rd3) rdata3 <= mem[mem_addr3];
  end

  always @(posedge clock)
    if (mem_rd3 && int'(mem_addr3) > max_addr3) max_addr3 <= int'(mem_addr3);

  stim_sequencer u_dut (
    .clock(clock), .reset(reset), .run(run), .halt(halt),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(rdata),
    .cts(cts), .ctr(ctr), .stim_out(stim), .busy(busy), .done(done),
    .timeout_err(terr), .pc(pc)
  );

  stim_sequencer #(.LAST_ADDR(3)) u_dut3 (
    .clock(clock), .reset(reset), .run(run3), .halt(halt),
    .mem_rd(mem_rd3), .mem_addr(mem_addr3), .mem_rdata(rdata3),
    .cts(cts), .ctr(ctr), .stim_out(stim3), .busy(busy3), .done(done3),
    .timeout_err(terr3), .pc(pc3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; outputs then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; run3 = 1'b0; halt = 1'b0; cts = 1'b0; ctr = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 16'hC000;
    repeat (3) tick();
    check("rst_stim", stim, 0);
    check("rst_pc", pc, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_terr", terr, 0);
    check("rst_mem_rd", mem_rd, 0);
    reset = 1'b0;
    tick();

    // Program A: APPLY h0, APPLY h3, END; run in cycle 0.
    mem[0] = 16'h0005; mem[1] = 16'h3081; mem[2] = 16'hC000;
    run = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      run = 1'b0;
      st[c] = stim; dn[c] = done; rd[c] = mem_rd;
    end
    check("a_fetch_rd_c1", rd[1], 1);
    check("a_stim_c2", st[2], 12'h000);
    check("a_stim_c3", st[3], 12'h005);
    check("a_stim_c5", st[5], 12'h005);
    for (int c = 6; c <= 9; c++) check($sformatf("a_stim_c%0d", c), st[c], 12'h081);
    check("a_done_c11", dn[11], 0);
    check("a_done_c12", dn[12], 1);
    check("a_stim_c12", st[12], 12'h081);
    check("a_pc_c12", pc, 2);
    check("a_busy_c12", busy, 0);

    // Reset while applying 0x3A5.
    mem[0] = 16'h33A5;
    run = 1'b1;
    for (int c = 1; c <= 3; c++) begin tick(); run = 1'b0; end
    check("r_stim_apply", stim, 12'h3A5);
    check("r_busy_apply", busy, 1);
    reset = 1'b1;
    tick();
    check("r_stim", stim, 0);
    check("r_pc", pc, 0);
    check("r_busy", busy, 0);
    check("r_done", done, 0);
    check("r_terr", terr, 0);
    reset = 1'b0;
    tick();

    // WAIT_CTS: stim visible cycle 3, cts high from cycle 10.
    mem[0] = 16'h4020; mem[1] = 16'hC000;
    run = 1'b1;
    for (int c = 1; c <= 10; c++) begin tick(); run = 1'b0; end
    check("w_pc_before", pc, 0);
    check("w_stim_held", stim, 12'h020);
    check("w_busy", busy, 1);
    cts = 1'b1;
    tick();
    cts = 1'b0;
    check("w_pc_adv", pc, 1);
    check("w_fetch_rd", mem_rd, 1);
    check("w_terr", terr, 0);
    tick(); tick();
    check("w_done", done, 1);

    // Timeout on WAIT_CTR at address 1: 255 wait cycles 7..261, DONE at 262.
    mem[0] = 16'h0001; mem[1] = 16'h8040;
    run = 1'b1;
    for (int c = 1; c <= 261; c++) begin
      tick();
      run = 1'b0;
      if (c == 6) check("t_stim_c6", stim, 12'h040);
    end
    check("t_done_c261", done, 0);
    check("t_busy_c261", busy, 1);
    tick();
    check("t_done", done, 1);
    check("t_terr", terr, 1);
    check("t_pc", pc, 1);
    check("t_stim", stim, 12'h040);

    // Halt from DONE keeps the sticky error.
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("h_busy", busy, 0);
    check("h_done", done, 0);
    check("h_stim", stim, 0);
    check("h_terr_kept", terr, 1);

    // run with halt in IDLE is ignored.
    run = 1'b1; halt = 1'b1;
    tick();
    run = 1'b0; halt = 1'b0;
    check("rh_mem_rd", mem_rd, 0);
    check("rh_busy", busy, 0);
    check("rh_terr", terr, 1);

    // Accepted run clears the error and fetches address 0.
    run = 1'b1;
    tick();
    run = 1'b0;
    check("rr_terr", terr, 0);
    check("rr_mem_rd", mem_rd, 1);
    check("rr_addr", mem_addr, 0);

    // Halt during WAIT (cycle 10) returns to IDLE with stim cleared.
    for (int c = 2; c <= 10; c++) tick();
    check("hw_busy_wait", busy, 1);
    check("hw_stim_wait", stim, 12'h040);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("hw_stim", stim, 0);
    check("hw_pc", pc, 0);
    check("hw_busy", busy, 0);
    check("hw_done", done, 0);
    tick();
    check("hw_idle_rd", mem_rd, 0);

    // LAST_ADDR=3 instance: four APPLY words, no END.
    mem[0] = 16'h0011; mem[1] = 16'h0022; mem[2] = 16'h1033;
    mem[3] = 16'h0044; mem[4] = 16'h0055;
    run3 = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      run3 = 1'b0;
      st[c] = stim3; dn[c] = done3;
    end
    check("l_stim_c3", st[3], 12'h011);
    check("l_stim_c6", st[6], 12'h022);
    check("l_stim_c9", st[9], 12'h033);
    check("l_stim_c10", st[10], 12'h033);
    check("l_stim_c13", st[13], 12'h044);
    check("l_done_c13", dn[13], 0);
    check("l_done_c14", dn[14], 1);
    check("l_pc", pc3, 3);
    repeat (3) tick();
    check("l_stim_held", stim3, 12'h044);
    check("l_done_held", done3, 1);
    check("l_max_addr", max_addr3, 3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/stim_sequencer.md
Name: stim_sequencer

Overview:
Programmable stimulus controller that drives the input vector of a benchmark DUT (b10-class voting controller) from a word memory.
- Fetches 16-bit program words and applies the 12-bit payload to the DUT inputs for a programmed number of cycles.
- Can stall on the DUT's cts/ctr handshake outputs before advancing.
- Replaces free-running program-counter stimulus with a start/halt/done-controlled engine usable from a bench or an on-chip test harness.

Parameters:
ADDR_W, 10, program memory address width
LAST_ADDR, 1000, last valid program address; executing it without an END word finishes the run
TIMEOUT, 255, maximum cycles spent in a handshake wait before abort (8-bit counter)

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
run  in  1  pulse: begin execution at address 0 (honoured in IDLE and DONE only)
halt  in  1  abort execution; has priority over run
mem_rd  out  1  program memory read strobe
mem_addr  out  ADDR_W  program memory address (equals pc)
mem_rdata  in  16  program word, valid the cycle after mem_rd
cts  in  1  DUT handshake output, wait condition for cmd WAIT_CTS
ctr  in  1  DUT handshake output, wait condition for cmd WAIT_CTR
stim_out  out  12  registered stimulus vector to DUT (bit 11 = __obs, [10:7] v_in, [6:0] rtr,rts,test,start,key,g_button,r_button)
busy  out  1  high in FETCH/LOAD/APPLY/WAIT
done  out  1  high in DONE
timeout_err  out  1  sticky; set on handshake timeout, cleared by reset or accepted run
pc  out  ADDR_W  current program address

Behaviour:
- Word format: [11:0] payload; [13:12] hold (payload applied hold+1 cycles); [15:14] cmd: 00 APPLY, 01 WAIT_CTS, 10 WAIT_CTR, 11 END.
- Reset: state IDLE, pc=0, stim_out=0, mem_rd=0, busy=0, done=0, timeout_err=0.
- IDLE: run=1 and halt=0 -> FETCH, pc=0, timeout_err cleared.
- FETCH: mem_rd=1, mem_addr=pc; next state LOAD. mem_rd is 0 in all other states.
- LOAD: decode mem_rdata.
  - cmd END -> DONE; stim_out unchanged.
  - Otherwise stim_out<=payload, hold counter<=hold -> APPLY.
  - stim_out changes exactly 2 cycles after FETCH.
- APPLY: counter decrements each cycle. At counter==0:
  - cmd APPLY -> advance.
  - cmd WAIT_CTS/WAIT_CTR -> WAIT, wait counter<=0.
- WAIT: selected signal sampled each cycle.
  - If high -> advance; stim_out held throughout.
  - If the wait counter reaches TIMEOUT with the signal still low -> timeout_err=1, DONE.
  - A signal already high on the first WAIT cycle advances after exactly 1 WAIT cycle.
- Advance: if pc==LAST_ADDR -> DONE, pc held; else pc<=pc+1 -> FETCH.
  - pc never wraps; no address beyond LAST_ADDR is read.
- DONE: stim_out and pc held. run=1 -> FETCH at pc=0, timeout_err cleared.
- halt=1 in any state except IDLE: next cycle IDLE, stim_out<=0, pc<=0; timeout_err preserved.
- halt and run together: halt wins; run ignored.
- run while busy: ignored.
- reset mid-operation: identical to power-on reset on the next edge, regardless of state.
- Per-word timing: cmd APPLY with hold h costs h+3 cycles (FETCH, LOAD, h+1 APPLY).

Decomposition:
- Package stim_seq_pkg:
  - cmd enum (CMD_APPLY, CMD_WAIT_CTS, CMD_WAIT_CTR, CMD_END)
  - state enum (IDLE, FETCH, LOAD, APPLY, WAIT, DONE)
  - field position constants (PAYLOAD_MSB=11, HOLD_LSB=12, CMD_LSB=14)
  - word width 16, stim width 12
- One sub-module is natural: stim_seq_timer, a loadable down-counter (hold) plus up-counter with terminal compare (timeout), shared by APPLY and WAIT.

Test Plan:
- Reset during APPLY with stim_out=0x3A5 -> next cycle stim_out=0, pc=0, busy=0, done=0, timeout_err=0.
- Program {0x0005 APPLY h0, 0x3081 APPLY h3, 0xC000 END}, run at cycle 0:
  - stim_out=0x005 at cycle 3.
  - stim_out=0x081 for cycles 6-9.
  - done=1 at cycle 12 with stim_out still 0x081.
- Word 0x4020 (WAIT_CTS, payload rts=1), cts raised 7 cycles after stim_out update -> pc advances on the cycle cts is sampled high, timeout_err=0.
- Word 0x8040 (WAIT_CTR), ctr held low -> after TIMEOUT=255 wait cycles timeout_err=1, done=1, pc unchanged. A following run clears timeout_err and fetches address 0.
- LAST_ADDR=3 with four APPLY words and no END -> words 0-3 applied, done=1, pc=3, mem_addr never exceeds 3.
- run and halt asserted together in IDLE -> stays IDLE. halt during WAIT -> IDLE next cycle, stim_out=0.
